bin_to_bcd_seq: RTL and testbench

Iterative binary-to-BCD converter using the shift-add-3 (double-dabble) method. It takes an unsigned binary value, such as the PC or a register value like x5, and produces packed BCD digits. These digits feed directly into the existing 7-segment digit decoder, one decoder input per digit. It uses a start/busy/done handshake and converts one bit per clock to keep area small on the FPGA.

---
 rtl/bin_to_bcd_seq_pkg.sv | 16 +
 rtl/bin_to_bcd_seq_digit_adj.sv | 15 +
 rtl/bin_to_bcd_seq.sv | 128 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t        : converter FSM state encoding
//   BCD_BLANK      : digit code the 7-segment decoder renders as dark
//   BCD_ADJ_THRESH : digit value at or above which double-dabble adds 3
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK      = 4'hF;
    localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
// Arithmetic wraps within the 4-bit digit.
//   digit_in  : scratch digit before the shift
//   digit_out : corrected digit
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per clock.
//   clock    : system clock, rising edge
//   reset    : asynchronous active-high reset
//   start    : conversion request, accepted only while idle
//   bin_in   : unsigned value, captured on the accepting edge
//   busy     : conversion in progress (shifting or presenting result)
//   done     : one-cycle pulse, bcd_out/overflow valid from this cycle
//   bcd_out  : packed digits, digit i in bits [4i+3:4i]; all 4'hF on overflow
//   overflow : value did not fit in DIGITS decimal digits
//
// state   | meaning
// IDLE    | waiting for start; results held
// SHIFT   | WIDTH cycles of adjust-then-shift
// DONE    | one cycle, done pulse, results just published
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int SCR_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [SCR_W-1:0]   scr_q, scr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [SCR_W-1:0]   bcd_out_q, bcd_out_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;

    logic [SCR_W-1:0]       scr_adj;
    logic [SCR_W+WIDTH:0]   shifted;
    logic                   ovf_next;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (scr_q[4*i +: 4]),
            .digit_out (scr_adj[4*i +: 4])
        );
    end

    // Top bit of the widened vector is whatever left the top scratch digit;
    // after correction that bit is set exactly when the value reaches 10^DIGITS.
    assign shifted  = {1'b0, scr_adj, bin_q} << 1;
    assign ovf_next = ovf_q | shifted[SCR_W+WIDTH];

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scr_d      = scr_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        bcd_out_d  = bcd_out_q;
        overflow_d = overflow_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = bin_in;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    ovf_d   = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bin_d = shifted[WIDTH-1:0];
                scr_d = shifted[SCR_W+WIDTH-1:WIDTH];
                ovf_d = ovf_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    overflow_d = ovf_next;
                    bcd_out_d  = ovf_next ? {DIGITS{BCD_BLANK}}
                                          : shifted[SCR_W+WIDTH-1:WIDTH];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            scr_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            bcd_out_q  <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scr_q      <= scr_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            bcd_out_q  <= bcd_out_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign bcd_out  = bcd_out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    localparam int WIDTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, start2;
    logic [7:0]  bin_in, bin_in2;
    logic        busy, done, overflow;
    logic        busy2, done2, overflow2;
    logic [11:0] bcd_out;
    logic [7:0]  bcd_out2;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clock = ~clock;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clock    (clock),
        .reset    (reset),
        .start    (start2),
        .bin_in   (bin_in2),
        .busy     (busy2),
        .done     (done2),
        .bcd_out  (bcd_out2),
        .overflow (overflow2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Decimal digits by plain arithmetic; out-of-range values become all-blank.
    function automatic logic [11:0] ref_bcd(input int unsigned v, input int unsigned d,
                                            output logic ovf);
        int unsigned lim = 1;
        int unsigned x   = v;
        logic [11:0] r   = '0;
        for (int i = 0; i < int'(d); i++) lim = lim * 10;
        ovf = (v >= lim);
        for (int i = 0; i < int'(d); i++) begin
            r[4*i +: 4] = ovf ? 4'hF : 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic run_conv(input int which, input logic [7:0] v, input bit noisy,
                            input string tag);
        int          busy_cyc = 0;
        int          done_cyc = 0;
        int          done_at  = -1;
        logic        b, d, o, eo;
        logic [11:0] q, eq;
        int unsigned dg;
        dg = (which == 0) ? 3 : 2;
        eq = ref_bcd(v, dg, eo);
        @(negedge clock);
        if (which == 0) begin bin_in = v; start = 1'b1; end
        else begin bin_in2 = v; start2 = 1'b1; end
        @(negedge clock);
        for (int c = 0; c < 40; c++) begin
            b = (which == 0) ? busy : busy2;
            d = (which == 0) ? done : done2;
            if (b) busy_cyc++;
            if (d) begin done_cyc++; done_at = c; end
            if (!b) begin
                start = 1'b0; start2 = 1'b0;
                break;
            end
            if (which == 0) begin
                start  = noisy ? 1'($urandom) : 1'b0;
                bin_in = 8'($urandom);
            end else begin
                start2  = noisy ? 1'($urandom) : 1'b0;
                bin_in2 = 8'($urandom);
            end
            @(negedge clock);
        end
        start = 1'b0; start2 = 1'b0;
        q = (which == 0) ? bcd_out : {4'h0, bcd_out2};
        o = (which == 0) ? overflow : overflow2;
        chk({tag, "_busy_cycles"}, busy_cyc, WIDTH + 1);
        chk({tag, "_done_count"}, done_cyc, 1);
        chk({tag, "_done_cycle"}, done_at, WIDTH);
        chk({tag, "_bcd"}, q, eq);
        chk({tag, "_ovf"}, o, eo);
        if (noisy) begin
            repeat (3) @(negedge clock);
            chk({tag, "_no_requeue"}, (which == 0) ? busy : busy2, 1'b0);
            chk({tag, "_hold_bcd"}, (which == 0) ? bcd_out : {4'h0, bcd_out2}, eq);
        end
    endtask

    initial begin
        logic [7:0]  vals[$];
        logic        eo;
        logic [11:0] eq;
        int          nd, last, dcount;

        reset = 1'b1; start = 1'b0; start2 = 1'b0; bin_in = '0; bin_in2 = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_bcd", bcd_out, 12'h000);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst2_bcd", bcd_out2, 8'h00);

        run_conv(0, 8'd255, 1'b0, "c255");

        // start held high: new conversion every WIDTH+2 cycles
        vals = '{8'd0, 8'd99, 8'd100};
        for (int i = 0; i < 3; i++) vals.push_back(8'($urandom));
        nd = 0; last = 0;
        @(negedge clock);
        bin_in = vals[0]; start = 1'b1;
        for (int c = 0; c < 400 && nd < vals.size(); c++) begin
            @(negedge clock);
            if (done) begin
                eq = ref_bcd(vals[nd], 3, eo);
                chk($sformatf("b2b%0d_bcd", nd), bcd_out, eq);
                chk($sformatf("b2b%0d_ovf", nd), overflow, eo);
                if (nd > 0) chk($sformatf("b2b%0d_period", nd), c - last, WIDTH + 2);
                last = c;
                nd++;
                if (nd < vals.size()) bin_in = vals[nd];
                else start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_count", nd, vals.size());
        repeat (3) @(negedge clock);
        chk("b2b_idle", busy, 1'b0);

        run_conv(0, 8'd42, 1'b1, "c42_noisy");

        // reset in the middle of a conversion
        @(negedge clock);
        bin_in = 8'd200; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("mid_busy_pre", busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_bcd", bcd_out, 12'h000);
        chk("mid_rst_ovf", overflow, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (done) dcount++;
        end
        chk("mid_no_done", dcount, 0);
        chk("mid_bcd_after", bcd_out, 12'h000);
        run_conv(0, 8'd13, 1'b0, "c13");

        for (int i = 0; i < 12; i++)
            run_conv(0, 8'($urandom), 1'(i % 2), $sformatf("rnd%0d", i));

        run_conv(1, 8'd100, 1'b0, "d2_100");
        run_conv(1, 8'd99, 1'b0, "d2_99");
        run_conv(1, 8'd255, 1'b1, "d2_255");
        for (int i = 0; i < 6; i++)
            run_conv(1, 8'($urandom), 1'b0, $sformatf("d2_rnd%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
